// File: rtl/ks10_stim_pkg.sv
// Shared types and elaboration-time helpers for the KS10 stimulus generator.
package ks10_stim_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 36;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EXEC = 2'd2
  } state_t;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit params_ok(input int unsigned rst_cycles,
                                   input int unsigned clken_div,
                                   input int unsigned msec_div,
                                   input int unsigned fifo_depth);
    return (rst_cycles >= 1) && (clken_div >= 1) && (msec_div >= 1) &&
           (fifo_depth >= 2) && is_pow2(fifo_depth);
  endfunction

  // Width of a counter that must hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ks10_stim_fifo.sv
// Synchronous command FIFO; the read head is always presented, pop just advances it.
module ks10_stim_fifo #(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic             empty_next,
  output logic             ready
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_next;

  always_comb count_next = count + (AW+1)'(push) - (AW+1)'(pop);

  assign full       = (count == (AW+1)'(DEPTH));
  assign empty      = (count == '0);
  assign empty_next = (count_next == '0);
  assign head       = mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      ready <= (count_next != (AW+1)'(DEPTH));
    end
  end

  // NOTE: storage is not reset; the pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ks10_stim_gen.sv
// KS10 control stimulus: reset sequencer, clken/msec dividers, run gating and console command FSM.
module ks10_stim_gen
  import ks10_stim_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned RST_CYCLES = 4,
  parameter int unsigned CLKEN_DIV  = 1,
  parameter int unsigned MSEC_DIV   = 50000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run_req,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  cpu_rst,
  output logic                  clken,
  output logic                  run,
  output logic                  msec_en,
  output logic                  execute,
  output logic [DATA_WIDTH-1:0] d,
  output logic                  busy
);

  if (!params_ok(RST_CYCLES, CLKEN_DIV, MSEC_DIV, FIFO_DEPTH)) begin : g_bad_params
    $error("ks10_stim_gen: illegal parameter set");
  end

  localparam int unsigned RST_W = cnt_width(RST_CYCLES);
  localparam int unsigned DIV_W = cnt_width(CLKEN_DIV);
  localparam int unsigned MS_W  = cnt_width(MSEC_DIV);

  logic [RST_W-1:0]      rst_cnt;
  logic [DIV_W-1:0]      div_cnt;
  logic [DIV_W-1:0]      div_next;
  logic [MS_W-1:0]       msec_cnt;
  logic                  tick;
  logic                  ms_wrap;
  state_t                state;
  state_t                state_next;
  logic                  pop;
  logic                  push;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_empty_next;
  logic [DATA_WIDTH-1:0] fifo_head;

  assign push = cmd_valid && cmd_ready && !fifo_full;

  ks10_stim_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .wdata      (cmd_data),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .empty_next (fifo_empty_next),
    .ready      (cmd_ready)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_cnt <= '0;
      cpu_rst <= 1'b1;
    end else if (cpu_rst) begin
      if (rst_cnt == RST_W'(RST_CYCLES - 1)) cpu_rst <= 1'b0;
      else                                   rst_cnt <= rst_cnt + 1'b1;
    end
  end

  // tick is the value clken takes after this edge, so msec_en, run and execute line up with it.
  always_comb begin
    div_next = (div_cnt == DIV_W'(CLKEN_DIV - 1)) ? '0 : div_cnt + 1'b1;
    tick     = !cpu_rst && (div_next == '0);
    ms_wrap  = (msec_cnt == MS_W'(MSEC_DIV - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt  <= '0;
      msec_cnt <= '0;
      clken    <= 1'b0;
      msec_en  <= 1'b0;
      run      <= 1'b0;
    end else begin
      if (!cpu_rst) div_cnt <= div_next;
      if (tick)     msec_cnt <= ms_wrap ? '0 : msec_cnt + 1'b1;
      clken   <= tick;
      msec_en <= tick && ms_wrap;
      if (cpu_rst)   run <= 1'b0;
      else if (tick) run <= run_req;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    unique case (state)
      IDLE: if (!cpu_rst && !fifo_empty) state_next = LOAD;
      LOAD: begin
        pop        = 1'b1;
        state_next = EXEC;
      end
      EXEC: if (clken) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      d       <= '0;
      execute <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_next;
      if (state == LOAD) d <= fifo_head;
      execute <= (state_next == EXEC) && tick;
      busy    <= (state_next != IDLE) || !fifo_empty_next;
    end
  end

endmodule

// File: tb/tb_ks10_stim_gen.sv
// Self-checking bench: three differently parameterised instances against a cycle-count model.
module tb_ks10_stim_gen;

  localparam int RC [3] = '{4, 40, 4};
  localparam int CD [3] = '{1, 3, 4};
  localparam int MD [3] = '{5, 5, 2};

  logic        clk = 1'b0;
  logic        rst;
  logic        vld  [3];
  logic [35:0] cdat [3];
  logic        rr   [3];
  logic        rdy  [3];
  logic        cpr  [3];
  logic        cke  [3];
  logic        runo [3];
  logic        mse  [3];
  logic        exe  [3];
  logic        bsy  [3];
  logic [35:0] dd   [3];

  int checks = 0;
  int errors = 0;
  int n [3];
  bit run_e [3];
  logic [35:0] q0 [$];
  logic [35:0] q1 [$];
  logic [35:0] q2 [$];

  ks10_stim_gen #(.DATA_WIDTH(36), .RST_CYCLES(4), .CLKEN_DIV(1), .MSEC_DIV(5), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .rst(rst), .run_req(rr[0]), .cmd_valid(vld[0]), .cmd_ready(rdy[0]),
    .cmd_data(cdat[0]), .cpu_rst(cpr[0]), .clken(cke[0]), .run(runo[0]), .msec_en(mse[0]),
    .execute(exe[0]), .d(dd[0]), .busy(bsy[0]));

  ks10_stim_gen #(.DATA_WIDTH(36), .RST_CYCLES(40), .CLKEN_DIV(3), .MSEC_DIV(5), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .rst(rst), .run_req(rr[1]), .cmd_valid(vld[1]), .cmd_ready(rdy[1]),
    .cmd_data(cdat[1]), .cpu_rst(cpr[1]), .clken(cke[1]), .run(runo[1]), .msec_en(mse[1]),
    .execute(exe[1]), .d(dd[1]), .busy(bsy[1]));

  ks10_stim_gen #(.DATA_WIDTH(36), .RST_CYCLES(4), .CLKEN_DIV(4), .MSEC_DIV(2), .FIFO_DEPTH(4)) u_c (
    .clk(clk), .rst(rst), .run_req(rr[2]), .cmd_valid(vld[2]), .cmd_ready(rdy[2]),
    .cmd_data(cdat[2]), .cpu_rst(cpr[2]), .clken(cke[2]), .run(runo[2]), .msec_en(mse[2]),
    .execute(exe[2]), .d(dd[2]), .busy(bsy[2]));

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: n = clk edges since rst fell; cpu_rst low from edge R, clken every D-th edge after that.
  function automatic bit clken_e(input int i, input int nn);
    return (nn > RC[i]) && (((nn - RC[i]) % CD[i]) == 0);
  endfunction

  function automatic bit msec_e(input int i, input int nn);
    return clken_e(i, nn) && ((((nn - RC[i]) / CD[i]) % MD[i]) == 0);
  endfunction

  task automatic sb_push(input int i, input logic [35:0] w);
    case (i)
      0:       q0.push_back(w);
      1:       q1.push_back(w);
      default: q2.push_back(w);
    endcase
  endtask

  function automatic int sb_size(input int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic sb_pop(input int i, output logic [35:0] w, output bit ok);
    ok = (sb_size(i) != 0);
    w  = '0;
    if (ok) begin
      case (i)
        0:       w = q0.pop_front();
        1:       w = q1.pop_front();
        default: w = q2.pop_front();
      endcase
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        n[i]     = 0;
        run_e[i] = 1'b0;
      end else begin
        n[i]++;
        if (clken_e(i, n[i])) run_e[i] = rr[i];
      end
    end
  end

  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (rst === 1'b1) begin
        check($sformatf("rst_cpu_rst[%0d]", i), cpr[i], 1);
        check($sformatf("rst_clken[%0d]", i), cke[i], 0);
        check($sformatf("rst_msec[%0d]", i), mse[i], 0);
        check($sformatf("rst_run[%0d]", i), runo[i], 0);
        check($sformatf("rst_exec[%0d]", i), exe[i], 0);
        check($sformatf("rst_ready[%0d]", i), rdy[i], 0);
        check($sformatf("rst_busy[%0d]", i), bsy[i], 0);
        check($sformatf("rst_d[%0d]", i), dd[i], 0);
      end else begin
        logic [35:0] w;
        bit ok;
        check($sformatf("cpu_rst[%0d]", i), cpr[i], n[i] < RC[i]);
        check($sformatf("clken[%0d]", i), cke[i], clken_e(i, n[i]));
        check($sformatf("msec_en[%0d]", i), mse[i], msec_e(i, n[i]));
        check($sformatf("run[%0d]", i), runo[i], run_e[i]);
        check($sformatf("exec_gate[%0d]", i), exe[i] & !clken_e(i, n[i]), 0);
        if (exe[i] === 1'b1) begin
          sb_pop(i, w, ok);
          check($sformatf("exec_expected[%0d]", i), ok, 1);
          if (ok) check($sformatf("exec_d[%0d]", i), dd[i], w);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) rr[i] = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) rr[i] = 1'($urandom_range(0, 1));
    end
  end

  task automatic push(input int i, input logic [35:0] w, input bit acc);
    vld[i]  = 1'b1;
    cdat[i] = w;
    @(posedge clk);
    if (acc) sb_push(i, w);
    @(negedge clk);
    vld[i] = 1'b0;
  endtask

  task automatic wait_drain(input int i, input int budget);
    for (int t = 0; t < budget && sb_size(i) != 0; t++) @(negedge clk);
    check($sformatf("drain[%0d]", i), sb_size(i), 0);
  endtask

  logic [35:0] fw [5] = '{36'o111111111111, 36'o222222222222, 36'o333333333333,
                          36'o444444444444, 36'o555555555555};

  initial begin
    for (int i = 0; i < 3; i++) begin
      vld[i]  = 1'b0;
      cdat[i] = '0;
    end
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset release on u_a: cpu_rst falls on the 4th edge, clken follows one edge later.
    repeat (3) @(negedge clk);
    check("rel_cpu_rst_e3", cpr[0], 1);
    check("rel_clken_e3", cke[0], 0);
    @(negedge clk);
    check("rel_cpu_rst_e4", cpr[0], 0);
    check("rel_clken_e4", cke[0], 0);
    @(negedge clk);
    check("rel_clken_e5", cke[0], 1);

    // FIFO full on u_b while its cpu_rst is still high.
    check("full_ready_init", rdy[1], 1);
    for (int j = 0; j < 5; j++) begin
      push(1, fw[j], j < 4);
      check($sformatf("full_ready_after%0d", j + 1), rdy[1], j < 3);
    end
    check("full_busy", bsy[1], 1);

    // Single command on u_a: execute and d in the cycle after E+2.
    push(0, 36'o123456701234, 1);
    check("sc_exec_e0", exe[0], 0);
    check("sc_d_e0", dd[0], 0);
    check("sc_busy_e0", bsy[0], 1);
    @(negedge clk);
    check("sc_exec_e1", exe[0], 0);
    @(negedge clk);
    check("sc_exec_e2", exe[0], 1);
    check("sc_d_e2", dd[0], 36'o123456701234);
    @(negedge clk);
    check("sc_exec_e3", exe[0], 0);
    check("sc_d_hold", dd[0], 36'o123456701234);

    // Back-to-back commands on u_a.
    push(0, 36'o000000000001, 1);
    push(0, 36'o777777777776, 1);
    push(0, 36'o252525252525, 1);
    wait_drain(0, 40);

    // Divider pins on u_b (R=40, D=3, M=5): first clken at edge 43, first msec at edge 55.
    for (int t = 0; t < 200 && n[1] < 43; t++) @(negedge clk);
    check("div_n43", n[1], 43);
    check("div_clken_43", cke[1], 1);
    check("div_msec_43", mse[1], 0);
    for (int t = 0; t < 200 && n[1] < 54; t++) @(negedge clk);
    check("div_clken_54", cke[1], 0);
    @(negedge clk);
    check("div_clken_55", cke[1], 1);
    check("div_msec_55", mse[1], 1);
    wait_drain(1, 300);

    // Reset mid-operation on u_c: EXEC entered on a non-clken cycle with 2 words still queued.
    for (int t = 0; t < 8 && (n[2] % 4) != 2; t++) @(negedge clk);
    push(2, 36'o101010101010, 1);
    push(2, 36'o202020202020, 1);
    push(2, 36'o303030303030, 1);
    check("mr_exec_before", exe[2], 0);
    check("mr_d_before", dd[2], 36'o101010101010);
    check("mr_busy_before", bsy[2], 1);
    #2 rst = 1'b1;
    q0.delete();
    q1.delete();
    q2.delete();
    @(negedge clk);
    check("mr_exec", exe[2], 0);
    check("mr_d", dd[2], 0);
    check("mr_busy", bsy[2], 0);
    @(negedge clk);
    rst = 1'b0;

    // Recovery after the abort.
    repeat (8) @(negedge clk);
    check("rec_busy_idle", bsy[2], 0);
    push(2, 36'o765432107654, 1);
    wait_drain(2, 40);
    repeat (10) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ks10_stim_gen.md
# ks10_stim_gen

Synthesizable control-stimulus generator for the KS10 core, taking over the job of a fixed simulation harness. It produces the core's reset, clock-enable, millisecond tick, run, execute and console data inputs from parameters and a host command stream. It sits between a host or test sequencer and the `KS10` instance. The same block drives the core on the FPGA and in simulation.

## Interface
Parameters:
- DATA_WIDTH, 36, width of console data word `d`
- RST_CYCLES, 4, `clk` cycles `cpu_rst` stays high after `rst` falls (>=1)
- CLKEN_DIV, 1, `clk` cycles per `clken` pulse (1 = `clken` constantly high)
- MSEC_DIV, 50000, `clken` ticks per `msec_en` pulse (>=1)
- FIFO_DEPTH, 4, command FIFO depth (power of 2, >=2)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- run_req  in  1  host level request for the CPU to run
- cmd_valid  in  1  host command word valid
- cmd_ready  out  1  FIFO can accept a word
- cmd_data  in  DATA_WIDTH  command word
- cpu_rst  out  1  reset to core
- clken  out  1  core clock enable
- run  out  1  core run
- msec_en  out  1  1 ms tick, one `clk` wide
- execute  out  1  execute strobe, one `clk` wide
- d  out  DATA_WIDTH  console data to core
- busy  out  1  FIFO non-empty or FSM not IDLE

## Operation
- Reset values while `rst`=1:
  - `cpu_rst`=1.
  - All other outputs 0, including `cmd_ready` and `d`.
  - FIFO flushed, all counters 0, FSM in IDLE.
- Reset sequencer:
  - Counter runs from `rst` deassertion.
  - `cpu_rst` falls after exactly RST_CYCLES rising edges.
- clken divider:
  - Counter runs modulo CLKEN_DIV.
  - `clken`=1 when the count is 0.
  - Runs only while `cpu_rst`=0.
- msec counter:
  - Increments on `clken` cycles.
  - On the cycle completing MSEC_DIV ticks, `msec_en`=1 (coincident with `clken`) and the counter wraps to 0.
  - MSEC_DIV=1 gives `msec_en`=`clken`.
- run: registers `run_req` on `clken` cycles only; held 0 while `cpu_rst`=1.
- FIFO:
  - `cmd_ready` = !full. It does not depend on a same-cycle pop.
  - A push occurs when `cmd_valid`&`cmd_ready`.
  - A push while full is impossible, since `cmd_ready`=0.
- FSM, states IDLE, LOAD, EXEC:
  - IDLE: go to LOAD if `cpu_rst`=0 and the FIFO is non-empty.
  - LOAD: `d` <= FIFO head, pop. Go to EXEC on the next edge.
  - EXEC: wait for a `clken`=1 cycle. In that cycle `execute`=1, then return to IDLE.
- `d` holds its value until the next LOAD and is never cleared except by `rst`.
- Simultaneous push and pop on a non-empty, non-full FIFO: the count is unchanged and data order is preserved.
- `rst` asserted mid-command: the FSM aborts immediately and the queued words are lost.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- CLKEN_DIV=1, idle FSM, word accepted at edge E:
  - LOAD is entered at E+1.
  - `d` is valid after E+2.
  - `execute` is high in cycle E+2..E+3.
- CLKEN_DIV>1: `execute` waits for the first `clken` cycle after LOAD. Worst-case added latency is CLKEN_DIV−1 cycles.
- `d` is stable for at least one cycle before `execute` rises and stays stable while it is high.
- Back-to-back commands: a minimum of 3 `clk` cycles between `execute` pulses when CLKEN_DIV=1.
- `msec_en` period = CLKEN_DIV×MSEC_DIV `clk` cycles. The first pulse comes that many cycles after `cpu_rst` falls.

## Structure
- Package `ks10_stim_pkg`:
  - FSM state enum (IDLE, LOAD, EXEC).
  - Default DATA_WIDTH constant (36).
  - Elaboration-time parameter checks: RST_CYCLES>=1, CLKEN_DIV>=1, MSEC_DIV>=1, FIFO_DEPTH a power of 2 and >=2.
- Sub-module `ks10_stim_fifo`:
  - Synchronous FIFO parameterised by width and depth.
  - Uses the same `clk`/`rst`.
  - Exposes full, empty, push, pop and head.
- Top level holds the reset sequencer, the two dividers and the FSM.

## Test plan
- Reset release, RST_CYCLES=4: `rst` falls at edge 0. Expect `cpu_rst` falling at edge 4, and all other outputs 0 until then.
- Divider check, CLKEN_DIV=3, MSEC_DIV=5: expect `clken` every 3rd cycle and `msec_en` every 15th cycle, coincident with `clken`.
- Single command, CLKEN_DIV=1: push 36'o123456701234 at edge E. Expect `d`=36'o123456701234 after E+2 and a one-cycle `execute` pulse in E+2..E+3.
- FIFO full, FIFO_DEPTH=4, `cpu_rst` held high:
  - Push 5 words. Expect `cmd_ready`=0 after the 4th and the 5th word not accepted.
  - After release, expect 4 `execute` pulses in push order.
- Reset mid-operation: assert `rst` while in EXEC with 2 words queued. Expect no `execute` pulse, `d`=0 and `busy`=0.
- run gating, CLKEN_DIV=4: toggle `run_req` between `clken` cycles. Expect `run` to change only on `clken` cycles.
